// File: rtl/prbs_ber_monitor_pkg.sv
// prbs_ber_monitor_pkg: shared types and PRBS tap constants for the BER monitor
package prbs_ber_monitor_pkg;

    typedef enum logic [1:0] {
        PRBS7  = 2'b00,
        PRBS15 = 2'b01,
        PRBS23 = 2'b10,
        PRBS31 = 2'b11
    } prbs_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HUNT   = 2'b01,
        LOCKED = 2'b10
    } prbs_state_t;

    localparam int HIST_W   = 31;
    localparam int PRBS7_A  = 7;
    localparam int PRBS7_B  = 6;
    localparam int PRBS15_A = 15;
    localparam int PRBS15_B = 14;
    localparam int PRBS23_A = 23;
    localparam int PRBS23_B = 18;
    localparam int PRBS31_A = 31;
    localparam int PRBS31_B = 28;

    function automatic int tap_a(input logic [1:0] m);
        return m == PRBS7 ? PRBS7_A : m == PRBS15 ? PRBS15_A : m == PRBS23 ? PRBS23_A : PRBS31_A;
    endfunction

    function automatic int tap_b(input logic [1:0] m);
        return m == PRBS7 ? PRBS7_B : m == PRBS15 ? PRBS15_B : m == PRBS23 ? PRBS23_B : PRBS31_B;
    endfunction

endpackage

// File: rtl/prbs_ber_monitor_popcount.sv
// prbs_popcount: combinational population count of a DATA_WIDTH vector
module prbs_popcount #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]         vec,
    output logic [$clog2(DATA_WIDTH+1)-1:0] cnt
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    // sum the set bits
    always_comb begin
        cnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) cnt = cnt + CW'(vec[i]);
    end

endmodule

// File: rtl/prbs_ber_monitor.sv
// prbs_ber_monitor: self-synchronising PRBS checker with lock FSM and saturating error-bit counter (optional err_inject via PRBS_ERR_INJECT_EN)
module prbs_ber_monitor
    import prbs_ber_monitor_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 10,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_ERR = 4
) (
    input  logic                  clk_390p625M,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  monitor_EN,
    input  logic [1:0]            prbs_mode,
    input  logic                  cnt_clear,
`ifdef PRBS_ERR_INJECT_EN
    input  logic                  err_inject,
`endif
    output logic                  prbs_sync_ready,
    output logic [CNT_WIDTH-1:0]  error_bit_count,
    output logic                  error_count_sat
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_ERR + 1);
    localparam int PW = $clog2(DATA_WIDTH + 1);
    localparam int SW = (CNT_WIDTH > PW ? CNT_WIDTH : PW) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    prbs_state_t state_q, state_d;
    prbs_mode_t  mode_q, mode_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic hist_ok_q, hist_ok_d;
    logic [GW-1:0] good_q, good_d;
    logic [BW-1:0] bad_q, bad_d;
    logic [DATA_WIDTH-1:0] err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic sat_q, sat_d, rdy_q, rdy_d;

    logic [DATA_WIDTH-1:0] rx, mism;
    logic [DATA_WIDTH-1:0] mv [4];
    logic [DATA_WIDTH+HIST_W-1:0] ext;
    logic [PW-1:0] pc;
    logic [SW-1:0] sum;
    logic mode_chg, clean, zero, cnt_en;

`ifdef PRBS_ERR_INJECT_EN
    assign rx = data_in ^ {{(DATA_WIDTH-1){1'b0}}, err_inject};
`else
    assign rx = data_in;
`endif

    // received word below its history: a higher index is an earlier bit
    assign ext = {hist_q, rx};

    for (genvar m = 0; m < 4; m++) begin : g_tap
        localparam int A = tap_a(2'(m));
        localparam int B = tap_b(2'(m));
        assign mv[m] = ext[DATA_WIDTH-1:0] ^ ext[DATA_WIDTH-1+A:A] ^ ext[DATA_WIDTH-1+B:B];
    end

    assign mism     = mv[prbs_mode];
    assign mode_chg = prbs_mode != mode_q;
    assign clean    = mism == '0;
    assign zero     = rx == '0;
    assign cnt_en   = monitor_EN && !mode_chg && data_valid && hist_ok_q && state_q == LOCKED;

    // FSM state and registered lock flag
    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
        end
    end

    // next state with good/bad word run counters; the first word after (re)hunt only primes history
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        bad_d     = bad_q;
        hist_ok_d = hist_ok_q;
        if (!monitor_EN) begin
            state_d   = IDLE;
            good_d    = '0;
            bad_d     = '0;
            hist_ok_d = 1'b0;
        end else if (state_q == IDLE || mode_chg) begin
            state_d   = HUNT;
            good_d    = '0;
            bad_d     = '0;
            hist_ok_d = 1'b0;
        end else if (data_valid) begin
            hist_ok_d = 1'b1;
            if (hist_ok_q && state_q == HUNT) begin
                good_d = clean && !zero ? good_q + 1'b1 : '0;
                if (good_d == GW'(LOCK_CNT)) begin
                    state_d = LOCKED;
                    good_d  = '0;
                end
            end else if (hist_ok_q) begin
                bad_d = clean ? '0 : bad_q + 1'b1;
                if (bad_d == BW'(UNLOCK_ERR)) begin
                    state_d   = HUNT;
                    bad_d     = '0;
                    hist_ok_d = 1'b0;
                end
            end
        end
    end

    // lock output follows the state being entered
    always_comb rdy_d = state_d == LOCKED;

    // history, stage-1 error vector and stage-2 saturating accumulation
    always_comb begin
        mode_d = prbs_mode_t'(prbs_mode);
        hist_d = data_valid ? rx[HIST_W-1:0] : hist_q;
        err_d  = cnt_en ? mism : '0;
        sum    = SW'(cnt_q) + SW'(pc);
        cnt_d  = cnt_clear ? '0 : sum > SW'(CNT_MAX) ? CNT_MAX : sum[CNT_WIDTH-1:0];
        sat_d  = !cnt_clear && cnt_d == CNT_MAX;
    end

    prbs_popcount #(.DATA_WIDTH(DATA_WIDTH)) u_popcount (
        .vec (err_q),
        .cnt (pc)
    );

    // datapath registers
    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= PRBS7;
            hist_q    <= '0;
            hist_ok_q <= 1'b0;
            good_q    <= '0;
            bad_q     <= '0;
            err_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            hist_q    <= hist_d;
            hist_ok_q <= hist_ok_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    assign prbs_sync_ready = rdy_q;
    assign error_bit_count = cnt_q;
    assign error_count_sat = sat_q;

endmodule
